// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipelined RV32I control (decode, EX branch resolve, hazards, forwarding, retire count)
// Ports: i_clk/i_reset (async high); i_inst/i_inst_vld from IF/ID; i_br_less/i_br_equal from EX comparator;
//        o_imm_sel (ID); o_stall/o_flush/o_pc_sel; o_ex_* ALU/branch controls; o_fwd_a/b; o_mem_dmem_we;
//        o_wb_reg_wen/o_wb_sel/o_wb_rd; o_retire_cnt
module pipe_ctrl #(
  parameter int FWD_EN = 1,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_inst,
  input  logic             i_inst_vld,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  output logic [2:0]       o_imm_sel,
  output logic             o_stall,
  output logic             o_flush,
  output logic             o_pc_sel,
  output logic [3:0]       o_ex_alu_op,
  output logic [1:0]       o_ex_alu_a_sel,
  output logic             o_ex_alu_b_sel,
  output logic             o_ex_br_un,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_mem_dmem_we,
  output logic             o_wb_reg_wen,
  output logic [1:0]       o_wb_sel,
  output logic [4:0]       o_wb_rd,
  output logic [CNT_W-1:0] o_retire_cnt
);
  typedef struct packed {
    logic       vld;
    logic [3:0] alu_op;
    logic [1:0] a_sel;
    logic       b_sel;
    logic       br;
    logic       jmp;
    logic [2:0] f3;
    logic       reg_wen;
    logic       dmem_we;
    logic       load;
    logic [1:0] wb_sel;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctl_t;
  logic [6:0] op;
  logic [2:0] f3;
  logic [3:0] f3_op;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_aui;
  logic id_v, use_rs1, use_rs2, use_rd;
  ctl_t id, ex;
  logic mem_vld, mem_wen, mem_we;
  logic [1:0] mem_wb_sel;
  logic [4:0] mem_rd;
  logic wb_vld, wb_wen;
  logic [1:0] wb_sel;
  logic [4:0] wb_rd;
  logic [CNT_W-1:0] cnt;
  logic taken, flush, ex_hit, mem_hit, hazard;
  logic unused_inst;
  assign op = i_inst[6:0];
  assign f3 = i_inst[14:12];
  assign is_r = op == 7'h33;
  assign is_i = op == 7'h13;
  assign is_ld = op == 7'h03;
  assign is_st = op == 7'h23;
  assign is_br = op == 7'h63;
  assign is_jal = op == 7'h6f;
  assign is_jalr = op == 7'h67;
  assign is_lui = op == 7'h37;
  assign is_aui = op == 7'h17;
  assign id_v = i_inst_vld & (is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_aui);
  assign use_rs1 = is_r | is_i | is_ld | is_st | is_br | is_jalr;
  assign use_rs2 = is_r | is_st | is_br;
  assign use_rd = is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_aui;
  assign unused_inst = &{i_inst[31], i_inst[29:25]};
  // inst[30] selects SUB only for R-type; for shifts it selects SRA in both R and OP-IMM
  always_comb begin
    case (f3)
      3'd0: f3_op = (is_r & i_inst[30]) ? 4'd1 : 4'd0;
      3'd1: f3_op = 4'd7;
      3'd2: f3_op = 4'd2;
      3'd3: f3_op = 4'd3;
      3'd4: f3_op = 4'd4;
      3'd5: f3_op = i_inst[30] ? 4'd9 : 4'd8;
      3'd6: f3_op = 4'd5;
      default: f3_op = 4'd6;
    endcase
  end
  // Unused source/dest fields are zeroed so they can never match in hazard or forward logic
  always_comb begin
    id = '0;
    if (id_v) begin
      id.vld = 1'b1;
      id.alu_op = (is_r | is_i) ? f3_op : 4'd0;
      id.a_sel = (is_br | is_jal | is_aui) ? 2'd1 : is_lui ? 2'd2 : 2'd0;
      id.b_sel = !is_r;
      id.br = is_br;
      id.jmp = is_jal | is_jalr;
      id.f3 = f3;
      id.reg_wen = use_rd;
      id.dmem_we = is_st;
      id.load = is_ld;
      id.wb_sel = is_ld ? 2'd0 : (is_jal | is_jalr) ? 2'd2 : 2'd1;
      id.rd = use_rd ? i_inst[11:7] : 5'd0;
      id.rs1 = use_rs1 ? i_inst[19:15] : 5'd0;
      id.rs2 = use_rs2 ? i_inst[24:20] : 5'd0;
    end
  end
  assign o_imm_sel = !i_inst_vld ? 3'd0 : is_st ? 3'd1 : is_br ? 3'd2 : is_jal ? 3'd3 : (is_lui | is_aui) ? 3'd4 : 3'd0;
  // f3[2] picks the less-than comparator, f3[0] inverts the sense (BNE/BGE/BGEU)
  assign taken = ex.jmp | (ex.br & ((ex.f3[2] ? i_br_less : i_br_equal) ^ ex.f3[0]));
  assign flush = ex.vld & taken;
  assign ex_hit = |ex.rd && (ex.rd == id.rs1 || ex.rd == id.rs2);
  assign mem_hit = |mem_rd && (mem_rd == id.rs1 || mem_rd == id.rs2);
  assign hazard = (FWD_EN != 0) ? (ex.load & ex_hit) : (ex_hit | mem_hit);
  assign o_stall = hazard & !flush;
  assign o_flush = flush;
  assign o_pc_sel = flush;
  assign o_ex_alu_op = ex.alu_op;
  assign o_ex_alu_a_sel = ex.a_sel;
  assign o_ex_alu_b_sel = ex.b_sel;
  assign o_ex_br_un = ex.br & ex.f3[1];
  assign o_fwd_a = (FWD_EN == 0) ? 2'd0 : (|mem_rd && mem_rd == ex.rs1) ? 2'd1 : (|wb_rd && wb_rd == ex.rs1) ? 2'd2 : 2'd0;
  assign o_fwd_b = (FWD_EN == 0) ? 2'd0 : (|mem_rd && mem_rd == ex.rs2) ? 2'd1 : (|wb_rd && wb_rd == ex.rs2) ? 2'd2 : 2'd0;
  assign o_mem_dmem_we = mem_we;
  assign o_wb_reg_wen = wb_wen;
  assign o_wb_sel = wb_sel;
  assign o_wb_rd = wb_rd;
  assign o_retire_cnt = cnt;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex <= '0;
      mem_vld <= 1'b0;
      mem_wen <= 1'b0;
      mem_we <= 1'b0;
      mem_wb_sel <= 2'd0;
      mem_rd <= 5'd0;
      wb_vld <= 1'b0;
      wb_wen <= 1'b0;
      wb_sel <= 2'd0;
      wb_rd <= 5'd0;
      cnt <= '0;
    end else begin
      ex <= (flush | hazard) ? '0 : id;
      mem_vld <= ex.vld;
      mem_wen <= ex.reg_wen;
      mem_we <= ex.dmem_we;
      mem_wb_sel <= ex.wb_sel;
      mem_rd <= ex.rd;
      wb_vld <= mem_vld;
      wb_wen <= mem_wen;
      wb_sel <= mem_wb_sel;
      wb_rd <= mem_rd;
      if (wb_vld) cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl with forwarding (dut) and without (dut0)
module tb_pipe_ctrl;
  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic [31:0] i_inst = 32'h0;
  logic i_inst_vld = 1'b0, i_br_less = 1'b0, i_br_equal = 1'b0;
  logic [2:0] o_imm_sel, n_imm_sel;
  logic o_stall, o_flush, o_pc_sel, n_stall, n_flush, n_pc_sel;
  logic [3:0] o_ex_alu_op, n_ex_alu_op;
  logic [1:0] o_ex_alu_a_sel, n_ex_alu_a_sel;
  logic o_ex_alu_b_sel, o_ex_br_un, n_ex_alu_b_sel, n_ex_br_un;
  logic [1:0] o_fwd_a, o_fwd_b, n_fwd_a, n_fwd_b;
  logic o_mem_dmem_we, o_wb_reg_wen, n_mem_dmem_we, n_wb_reg_wen;
  logic [1:0] o_wb_sel, n_wb_sel;
  logic [4:0] o_wb_rd, n_wb_rd;
  logic [31:0] o_retire_cnt, n_retire_cnt;
  logic [58:0] all1, all0;
  int errors = 0;
  int checks = 0;
  typedef struct packed {
    logic [31:0] inst;
    logic [3:0] alu;
    logic [1:0] a;
    logic b;
    logic [2:0] imm;
    logic pc;
  } dvec_t;
  dvec_t dtab [15];

  always #5 i_clk = ~i_clk;

  pipe_ctrl #(.FWD_EN(1), .CNT_W(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_inst(i_inst), .i_inst_vld(i_inst_vld),
    .i_br_less(i_br_less), .i_br_equal(i_br_equal), .o_imm_sel(o_imm_sel), .o_stall(o_stall),
    .o_flush(o_flush), .o_pc_sel(o_pc_sel), .o_ex_alu_op(o_ex_alu_op), .o_ex_alu_a_sel(o_ex_alu_a_sel),
    .o_ex_alu_b_sel(o_ex_alu_b_sel), .o_ex_br_un(o_ex_br_un), .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
    .o_mem_dmem_we(o_mem_dmem_we), .o_wb_reg_wen(o_wb_reg_wen), .o_wb_sel(o_wb_sel), .o_wb_rd(o_wb_rd),
    .o_retire_cnt(o_retire_cnt));

  pipe_ctrl #(.FWD_EN(0), .CNT_W(32)) dut0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_inst(i_inst), .i_inst_vld(i_inst_vld),
    .i_br_less(i_br_less), .i_br_equal(i_br_equal), .o_imm_sel(n_imm_sel), .o_stall(n_stall),
    .o_flush(n_flush), .o_pc_sel(n_pc_sel), .o_ex_alu_op(n_ex_alu_op), .o_ex_alu_a_sel(n_ex_alu_a_sel),
    .o_ex_alu_b_sel(n_ex_alu_b_sel), .o_ex_br_un(n_ex_br_un), .o_fwd_a(n_fwd_a), .o_fwd_b(n_fwd_b),
    .o_mem_dmem_we(n_mem_dmem_we), .o_wb_reg_wen(n_wb_reg_wen), .o_wb_sel(n_wb_sel), .o_wb_rd(n_wb_rd),
    .o_retire_cnt(n_retire_cnt));

  assign all1 = {o_imm_sel, o_stall, o_flush, o_pc_sel, o_ex_alu_op, o_ex_alu_a_sel, o_ex_alu_b_sel, o_ex_br_un,
                 o_fwd_a, o_fwd_b, o_mem_dmem_we, o_wb_reg_wen, o_wb_sel, o_wb_rd, o_retire_cnt};
  assign all0 = {n_imm_sel, n_stall, n_flush, n_pc_sel, n_ex_alu_op, n_ex_alu_a_sel, n_ex_alu_b_sel, n_ex_br_un,
                 n_fwd_a, n_fwd_b, n_mem_dmem_we, n_wb_reg_wen, n_wb_sel, n_wb_rd, n_retire_cnt};

  task automatic cyc(input logic [31:0] inst, input logic vld);
    @(posedge i_clk);
    #1;
    i_inst = inst;
    i_inst_vld = vld;
    @(negedge i_clk);
  endtask

  task automatic do_reset;
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    i_inst_vld = 1'b0;
    i_br_less = 1'b0;
    i_br_equal = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge i_clk);
    @(negedge i_clk);
    checks++; if (all1 !== 59'd0) begin errors++; $display("FAIL reset_fwd: got %h expected 0", all1); end
    checks++; if (all0 !== 59'd0) begin errors++; $display("FAIL reset_nofwd: got %h expected 0", all0); end
  endtask

  task automatic test_fwd;
    do_reset;
    cyc(32'h00500093, 1'b1);
    checks++; if ({o_imm_sel, o_stall} !== 4'b0) begin errors++; $display("FAIL fwd_id_addi: got %b expected 0000", {o_imm_sel, o_stall}); end
    cyc(32'h00108133, 1'b1);
    checks++; if ({o_ex_alu_op, o_ex_alu_a_sel, o_ex_alu_b_sel, o_stall} !== 8'b0000_00_1_0) begin errors++; $display("FAIL fwd_ex_addi: got %b expected 00000010", {o_ex_alu_op, o_ex_alu_a_sel, o_ex_alu_b_sel, o_stall}); end
    cyc(32'h0, 1'b0);
    checks++; if ({o_fwd_a, o_fwd_b, o_ex_alu_b_sel, o_stall} !== 6'b01_01_0_0) begin errors++; $display("FAIL fwd_ex_add: got %b expected 010100", {o_fwd_a, o_fwd_b, o_ex_alu_b_sel, o_stall}); end
    cyc(32'h0, 1'b0);
    checks++; if ({o_wb_reg_wen, o_wb_sel, o_wb_rd} !== {1'b1, 2'd1, 5'd1}) begin errors++; $display("FAIL fwd_wb_addi: got %b expected %b", {o_wb_reg_wen, o_wb_sel, o_wb_rd}, {1'b1, 2'd1, 5'd1}); end
    cyc(32'h0, 1'b0);
    checks++; if ({o_wb_rd, o_retire_cnt} !== {5'd2, 32'd1}) begin errors++; $display("FAIL fwd_wb_add: got rd=%0d cnt=%0d expected rd=2 cnt=1", o_wb_rd, o_retire_cnt); end
    cyc(32'h0, 1'b0);
    checks++; if (o_retire_cnt !== 32'd2) begin errors++; $display("FAIL fwd_cnt: got %0d expected 2", o_retire_cnt); end
  endtask

  task automatic test_priority;
    do_reset;
    cyc(32'h00500093, 1'b1);
    cyc(32'h00108093, 1'b1);
    checks++; if ({o_fwd_a, o_fwd_b} !== 4'b0000) begin errors++; $display("FAIL prio_c2: got %b expected 0000", {o_fwd_a, o_fwd_b}); end
    cyc(32'h40108133, 1'b1);
    checks++; if ({o_fwd_a, o_fwd_b} !== 4'b0100) begin errors++; $display("FAIL prio_c3: got %b expected 0100", {o_fwd_a, o_fwd_b}); end
    cyc(32'h0, 1'b0);
    checks++; if ({o_fwd_a, o_fwd_b, o_ex_alu_op} !== 8'b01_01_0001) begin errors++; $display("FAIL prio_c4: got %b expected 01010001", {o_fwd_a, o_fwd_b, o_ex_alu_op}); end
  endtask

  task automatic test_load_use;
    do_reset;
    cyc(32'h0000A283, 1'b1);
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL lu_c1_stall: got %b expected 0", o_stall); end
    cyc(32'h00228333, 1'b1);
    checks++; if ({o_stall, o_flush} !== 2'b10) begin errors++; $display("FAIL lu_c2_stall: got %b expected 10", {o_stall, o_flush}); end
    cyc(32'h00228333, 1'b1);
    checks++; if ({o_stall, o_mem_dmem_we, o_fwd_a, o_fwd_b} !== 6'b0) begin errors++; $display("FAIL lu_c3: got %b expected 000000", {o_stall, o_mem_dmem_we, o_fwd_a, o_fwd_b}); end
    cyc(32'h0, 1'b0);
    checks++; if ({o_fwd_a, o_fwd_b, o_stall} !== 5'b10_00_0) begin errors++; $display("FAIL lu_c4_fwd: got %b expected 10000", {o_fwd_a, o_fwd_b, o_stall}); end
    checks++; if ({o_wb_reg_wen, o_wb_sel, o_wb_rd} !== {1'b1, 2'd0, 5'd5}) begin errors++; $display("FAIL lu_c4_wb: got %b expected %b", {o_wb_reg_wen, o_wb_sel, o_wb_rd}, {1'b1, 2'd0, 5'd5}); end
    cyc(32'h0, 1'b0);
    cyc(32'h0, 1'b0);
    checks++; if ({o_wb_reg_wen, o_wb_rd} !== {1'b1, 5'd6}) begin errors++; $display("FAIL lu_c6_wb: got %b expected %b", {o_wb_reg_wen, o_wb_rd}, {1'b1, 5'd6}); end
    cyc(32'h0, 1'b0);
    cyc(32'h0, 1'b0);
    checks++; if (o_retire_cnt !== 32'd2) begin errors++; $display("FAIL lu_cnt: got %0d expected 2", o_retire_cnt); end
  endtask

  task automatic test_no_fwd;
    do_reset;
    cyc(32'h0000A283, 1'b1);
    cyc(32'h00228333, 1'b1);
    checks++; if ({n_stall, n_fwd_a, n_fwd_b} !== 5'b1_00_00) begin errors++; $display("FAIL nf_c2: got %b expected 10000", {n_stall, n_fwd_a, n_fwd_b}); end
    cyc(32'h00228333, 1'b1);
    checks++; if ({n_stall, n_fwd_a, n_fwd_b} !== 5'b1_00_00) begin errors++; $display("FAIL nf_c3: got %b expected 10000", {n_stall, n_fwd_a, n_fwd_b}); end
    cyc(32'h00228333, 1'b1);
    checks++; if (n_stall !== 1'b0) begin errors++; $display("FAIL nf_c4: got %b expected 0", n_stall); end
    cyc(32'h0, 1'b0);
    checks++; if ({n_fwd_a, n_fwd_b, n_stall} !== 5'b0) begin errors++; $display("FAIL nf_c5_fwd: got %b expected 00000", {n_fwd_a, n_fwd_b, n_stall}); end
    cyc(32'h0, 1'b0);
    cyc(32'h0, 1'b0);
    checks++; if ({n_wb_reg_wen, n_wb_rd} !== {1'b1, 5'd6}) begin errors++; $display("FAIL nf_c7_wb: got %b expected %b", {n_wb_reg_wen, n_wb_rd}, {1'b1, 5'd6}); end
  endtask

  task automatic test_branch;
    do_reset;
    i_br_equal = 1'b1;
    cyc(32'h00000463, 1'b1);
    checks++; if (o_imm_sel !== 3'd2) begin errors++; $display("FAIL br_imm: got %0d expected 2", o_imm_sel); end
    cyc(32'h00500093, 1'b1);
    checks++; if ({o_pc_sel, o_flush, o_stall} !== 3'b110) begin errors++; $display("FAIL br_taken: got %b expected 110", {o_pc_sel, o_flush, o_stall}); end
    checks++; if ({o_ex_alu_op, o_ex_alu_a_sel, o_ex_alu_b_sel, o_ex_br_un} !== 8'b0000_01_1_0) begin errors++; $display("FAIL br_ex: got %b expected 00000110", {o_ex_alu_op, o_ex_alu_a_sel, o_ex_alu_b_sel, o_ex_br_un}); end
    cyc(32'h0, 1'b0);
    checks++; if ({o_pc_sel, o_flush, o_ex_alu_a_sel, o_ex_alu_b_sel} !== 5'b0) begin errors++; $display("FAIL br_squash: got %b expected 00000", {o_pc_sel, o_flush, o_ex_alu_a_sel, o_ex_alu_b_sel}); end
    cyc(32'h123453B7, 1'b1);
    checks++; if ({o_imm_sel, o_wb_reg_wen} !== 4'b100_0) begin errors++; $display("FAIL br_c4: got %b expected 1000", {o_imm_sel, o_wb_reg_wen}); end
    cyc(32'h0, 1'b0);
    checks++; if ({o_ex_alu_a_sel, o_ex_alu_b_sel, o_flush, o_wb_reg_wen} !== 5'b10_1_0_0) begin errors++; $display("FAIL br_c5: got %b expected 10100", {o_ex_alu_a_sel, o_ex_alu_b_sel, o_flush, o_wb_reg_wen}); end
    cyc(32'h0, 1'b0);
    checks++; if (o_wb_reg_wen !== 1'b0) begin errors++; $display("FAIL br_c6_wen: got %b expected 0", o_wb_reg_wen); end
    cyc(32'h0, 1'b0);
    checks++; if ({o_wb_reg_wen, o_wb_rd, o_retire_cnt} !== {1'b1, 5'd7, 32'd1}) begin errors++; $display("FAIL br_c7: got wen=%b rd=%0d cnt=%0d expected wen=1 rd=7 cnt=1", o_wb_reg_wen, o_wb_rd, o_retire_cnt); end
    cyc(32'h0, 1'b0);
    checks++; if (o_retire_cnt !== 32'd2) begin errors++; $display("FAIL br_cnt: got %0d expected 2", o_retire_cnt); end
    i_br_equal = 1'b0;
  endtask

  task automatic test_unknown;
    do_reset;
    cyc(32'h0000007F, 1'b1);
    checks++; if ({o_imm_sel, o_stall} !== 4'b0) begin errors++; $display("FAIL unk_c1: got %b expected 0000", {o_imm_sel, o_stall}); end
    cyc(32'h0000007F, 1'b1);
    checks++; if ({o_ex_alu_op, o_ex_alu_a_sel, o_ex_alu_b_sel, o_ex_br_un, o_flush} !== 9'b0) begin errors++; $display("FAIL unk_c2_ex: got %b expected 0", {o_ex_alu_op, o_ex_alu_a_sel, o_ex_alu_b_sel, o_ex_br_un, o_flush}); end
    cyc(32'h0020A223, 1'b1);
    checks++; if ({o_imm_sel, o_mem_dmem_we} !== 4'b001_0) begin errors++; $display("FAIL unk_c3: got %b expected 0010", {o_imm_sel, o_mem_dmem_we}); end
    cyc(32'h0000007F, 1'b1);
    checks++; if ({o_ex_alu_b_sel, o_wb_reg_wen} !== 2'b10) begin errors++; $display("FAIL unk_c4: got %b expected 10", {o_ex_alu_b_sel, o_wb_reg_wen}); end
    i_br_less = 1'b1;
    cyc(32'h0020E463, 1'b1);
    checks++; if ({o_imm_sel, o_mem_dmem_we, o_wb_reg_wen, o_stall} !== 6'b010_1_0_0) begin errors++; $display("FAIL unk_c5: got %b expected 010100", {o_imm_sel, o_mem_dmem_we, o_wb_reg_wen, o_stall}); end
    checks++; if (o_retire_cnt !== 32'd0) begin errors++; $display("FAIL unk_c5_cnt: got %0d expected 0", o_retire_cnt); end
    cyc(32'h0, 1'b0);
    checks++; if ({o_ex_br_un, o_pc_sel, o_flush} !== 3'b111) begin errors++; $display("FAIL bltu_taken: got %b expected 111", {o_ex_br_un, o_pc_sel, o_flush}); end
    checks++; if ({o_mem_dmem_we, o_wb_reg_wen, o_retire_cnt} !== 34'd0) begin errors++; $display("FAIL unk_c6: got dmem=%b wen=%b cnt=%0d expected 0 0 0", o_mem_dmem_we, o_wb_reg_wen, o_retire_cnt); end
    cyc(32'h0, 1'b0);
    checks++; if (o_retire_cnt !== 32'd1) begin errors++; $display("FAIL unk_c7_cnt: got %0d expected 1", o_retire_cnt); end
    i_br_less = 1'b0;
  endtask

  task automatic test_decode;
    dtab = '{
      '{32'h4030D093, 4'd9, 2'd0, 1'b1, 3'd0, 1'b0},
      '{32'h0030D093, 4'd8, 2'd0, 1'b1, 3'd0, 1'b0},
      '{32'h0020C1B3, 4'd4, 2'd0, 1'b0, 3'd0, 1'b0},
      '{32'h40000093, 4'd0, 2'd0, 1'b1, 3'd0, 1'b0},
      '{32'h123453B7, 4'd0, 2'd2, 1'b1, 3'd4, 1'b0},
      '{32'h00001097, 4'd0, 2'd1, 1'b1, 3'd4, 1'b0},
      '{32'h000000EF, 4'd0, 2'd1, 1'b1, 3'd3, 1'b1},
      '{32'h000080E7, 4'd0, 2'd0, 1'b1, 3'd0, 1'b1},
      '{32'h40108133, 4'd1, 2'd0, 1'b0, 3'd0, 1'b0},
      '{32'h0020A1B3, 4'd2, 2'd0, 1'b0, 3'd0, 1'b0},
      '{32'h0020B1B3, 4'd3, 2'd0, 1'b0, 3'd0, 1'b0},
      '{32'h0020E1B3, 4'd5, 2'd0, 1'b0, 3'd0, 1'b0},
      '{32'h0020F1B3, 4'd6, 2'd0, 1'b0, 3'd0, 1'b0},
      '{32'h002091B3, 4'd7, 2'd0, 1'b0, 3'd0, 1'b0},
      '{32'h0020A223, 4'd0, 2'd0, 1'b1, 3'd1, 1'b0}
    };
    do_reset;
    for (int i = 0; i < 15; i++) begin
      cyc(dtab[i].inst, 1'b1);
      checks++; if (o_imm_sel !== dtab[i].imm) begin errors++; $display("FAIL dec_imm[%0d]: got %0d expected %0d", i, o_imm_sel, dtab[i].imm); end
      cyc(32'h0, 1'b0);
      checks++; if ({o_ex_alu_op, o_ex_alu_a_sel, o_ex_alu_b_sel, o_pc_sel} !== {dtab[i].alu, dtab[i].a, dtab[i].b, dtab[i].pc}) begin
        errors++; $display("FAIL dec_ex[%0d]: got %b expected %b", i, {o_ex_alu_op, o_ex_alu_a_sel, o_ex_alu_b_sel, o_pc_sel}, {dtab[i].alu, dtab[i].a, dtab[i].b, dtab[i].pc});
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    cyc(32'h0000A283, 1'b1);
    cyc(32'h00228333, 1'b1);
    checks++; if ({o_stall, n_stall} !== 2'b11) begin errors++; $display("FAIL rm_pending: got %b expected 11", {o_stall, n_stall}); end
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    @(negedge i_clk);
    checks++; if (all1 !== 59'd0) begin errors++; $display("FAIL rm_during_fwd: got %h expected 0", all1); end
    checks++; if (all0 !== 59'd0) begin errors++; $display("FAIL rm_during_nofwd: got %h expected 0", all0); end
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    i_inst_vld = 1'b0;
    @(negedge i_clk);
    checks++; if (all1 !== 59'd0) begin errors++; $display("FAIL rm_after_fwd: got %h expected 0", all1); end
    checks++; if (all0 !== 59'd0) begin errors++; $display("FAIL rm_after_nofwd: got %h expected 0", all0); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_fwd;
    test_priority;
    test_load_use;
    test_no_fwd;
    test_branch;
    test_unknown;
    test_decode;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipelined successor to the single-cycle RV32I controller.
- Decodes the instruction held in the IF/ID register and carries a control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Resolves branches and jumps in EX. Detects RAW and load-use hazards, generates forwarding selects and stall/flush controls, and counts retired instructions.
- Sits between the IF/ID pipeline register and the datapath stage muxes.

Parameters:
- FWD_EN, 1: 1 = forwarding from MEM/WB with stalls only for load-use; 0 = no forwarding, stall on any RAW hazard against EX or MEM.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous active-high reset.
- i_inst  in  32  instruction from the IF/ID register (ID stage).
- i_inst_vld  in  1  IF/ID holds a real instruction.
- i_br_less  in  1  EX comparator: rs1 < rs2 (signedness per o_ex_br_un).
- i_br_equal  in  1  EX comparator: rs1 == rs2.
- o_imm_sel  out  3  ID immediate format: I=0, S=1, B=2, J=3, U=4.
- o_stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- o_flush  out  1  squash IF/ID and ID/EX.
- o_pc_sel  out  1  1 = next PC is the EX ALU result (branch/jump target).
- o_ex_alu_op  out  4  ALU op: ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9.
- o_ex_alu_a_sel  out  2  0 = rs1, 1 = PC, 2 = zero.
- o_ex_alu_b_sel  out  1  0 = rs2, 1 = imm.
- o_ex_br_un  out  1  1 = unsigned compare.
- o_fwd_a  out  2  EX operand A source: 0 = regfile, 1 = EX/MEM ALU result, 2 = WB data.
- o_fwd_b  out  2  same encoding, operand B.
- o_mem_dmem_we  out  1  store enable in MEM.
- o_wb_reg_wen  out  1  register write in WB.
- o_wb_sel  out  2  0 = load data, 1 = ALU, 2 = PC+4.
- o_wb_rd  out  5  WB destination register.
- o_retire_cnt  out  CNT_W  count of valid instructions reaching WB.

Behaviour:
- Reset (async, i_reset=1): all three pipeline registers become bubbles (valid=0, reg_wen=0, dmem_we=0, branch/jump flags=0, rd=0). All registered outputs are 0 and o_retire_cnt=0. Combinational outputs follow from the bubbles. Reset may arrive mid-stall or mid-flush; state is cleared with no residue.
- ID decode:
  - R type: alu_op from funct3 and inst[30].
  - OP-IMM: alu_op from funct3; inst[30] is used only for SRAI.
  - Load and store: a=rs1, b=imm, ADD.
  - Branch: a=PC, b=imm, ADD.
  - JAL: a=PC, b=imm, ADD.
  - JALR: a=rs1, b=imm, ADD.
  - LUI: a=zero, b=imm.
  - AUIPC: a=PC, b=imm.
  - dmem_we=1 only for stores.
  - Unknown opcode, or i_inst_vld=0: enters as a bubble, never X.
- rs1 is used by R, OP-IMM, load, store, branch and JALR. rs2 is used by R, store and branch. rd is written by R, OP-IMM, load, JAL, JALR, LUI and AUIPC. rd=0 never causes a hazard or a forward.
- Branch resolution (EX, combinational):
  - BEQ: taken = eq.
  - BNE: taken = !eq.
  - BLT: taken = less, br_un=0.
  - BGE: taken = !less, br_un=0.
  - BLTU: taken = less, br_un=1.
  - BGEU: taken = !less, br_un=1.
  - JAL and JALR: always taken.
  - o_pc_sel = o_flush = valid EX branch/jump & taken. Penalty is 2 cycles.
- Forwarding (FWD_EN=1): for each EX source, MEM match (reg_wen, rd==rs) gives 1. Otherwise WB match gives 2. Otherwise 0. MEM has priority over WB. With FWD_EN=0 both selects are tied to 0.
- Stall:
  - FWD_EN=1: stall = ID uses rs, EX is a valid load, and EX rd==rs≠0.
  - FWD_EN=0: stall = ID rs matches a writing EX or MEM rd≠0. The register file is write-first, so WB is not a hazard.
  - Stall lasts exactly as long as the condition holds: 1 cycle for load-use.
- Flush overrides stall in the same cycle: o_stall=0, and ID/EX loads a bubble.
- EX/MEM and MEM/WB always advance; they are never stalled.
- o_retire_cnt increments on every cycle the MEM/WB register holds valid=1 and wraps at 2^CNT_W.

Test Plan:
- Reset asserted mid-stream with a load-use pending -> all outputs 0 during reset and the first cycle after; o_retire_cnt=0.
- addi x1,x0,5 (0x00500093) then add x2,x1,x1 (0x00108133), FWD_EN=1 -> add in EX with o_fwd_a=o_fwd_b=1; no stall.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x2 (0x00228333) -> o_stall=1 for exactly 1 cycle, then o_fwd_a=2, o_fwd_b=0.
- Same pair with FWD_EN=0 -> o_stall=1 for 2 cycles; fwd selects stay 0.
- beq x0,x0,+8 (0x00000463) with i_br_equal=1 -> in EX o_pc_sel=o_flush=1 for 1 cycle; the two younger instructions never raise o_wb_reg_wen; o_retire_cnt excludes them.
- Stream of unknown opcode 0x0000007F -> o_mem_dmem_we=o_wb_reg_wen=0 and o_retire_cnt unchanged; bltu with i_br_less=1 -> o_ex_br_un=1, o_pc_sel=1.
